// File: rtl/design2_unpack.sv
// design2_unpack: recovers the per-sample increment and the unknown multiplicand
// from the running-sum (s_in) and product (p_in) streams of the accumulate/multiply
// datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   in_valid     sample present on s_in/p_in/b_in
//   in_ready     block can accept a sample (IDLE only)
//   s_in         running-sum sample (DW)
//   p_in         product sample (2*DW)
//   b_in         divisor, the known multiplier operand (DW)
//   out_valid    result present (DONE only)
//   out_ready    consumer accepts result
//   d_out        s_in minus previous accepted s_in, mod 2^DW
//   q_out        p_in / b_in (2*DW)
//   r_out        p_in mod b_in (DW)
//   div_by_zero  result came from b_in == 0 (q_out/r_out forced to all ones)
module design2_unpack #(
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   s_in,
    input  logic [2*DW-1:0] p_in,
    input  logic [DW-1:0]   b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   d_out,
    output logic [2*DW-1:0] q_out,
    output logic [DW-1:0]   r_out,
    output logic            div_by_zero
);

    localparam int unsigned QW = 2 * DW;
    localparam int unsigned CW = $clog2(QW);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e          r_state;
    logic [QW-1:0]   r_dvd;      // dividend, shifted out MSB first; quotient bits shift in at LSB
    logic [DW-1:0]   r_dvs;
    logic [DW:0]     r_rem;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_prev;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_d;
    logic [QW-1:0]   r_q;
    logic [DW-1:0]   r_r;
    logic            r_dz;

    logic [DW:0]     w_rem_shift;
    logic            w_rem_ge;
    logic [DW:0]     w_rem_next;
    logic [QW-1:0]   w_dvd_next;
    logic            w_last;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // The remainder is always < divisor before the shift, so DW+1 bits suffice.
    assign w_rem_shift = (r_rem << 1) | {{DW{1'b0}}, r_dvd[QW-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_dvs});
    assign w_rem_next  = w_rem_ge ? (w_rem_shift - {1'b0, r_dvs}) : w_rem_shift;
    assign w_dvd_next  = {r_dvd[QW-2:0], w_rem_ge};
    assign w_last      = (r_cnt == CW'(QW - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_prev      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid && r_in_ready) begin
                        r_d        <= s_in - r_prev;
                        r_prev     <= s_in;
                        r_dvd      <= p_in;
                        r_dvs      <= b_in;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (b_in != '0) begin
                            r_state <= StDiv;
                        end else begin
                            // Zero divisor: result is ready now; out_valid rises
                            // on the first DONE edge, one cycle after accept.
                            r_q     <= '1;
                            r_r     <= '1;
                            r_dz    <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StDiv: begin
                    r_dvd <= w_dvd_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_q         <= w_dvd_next;
                        r_r         <= w_rem_next[DW-1:0];
                        r_dz        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign d_out       = r_d;
    assign q_out       = r_q;
    assign r_out       = r_r;
    assign div_by_zero = r_dz;

endmodule

// File: doc/design2_unpack.md
Name: design2_unpack

Overview:
- Recovery and check block for the accumulate/multiply datapath. It takes the running-sum stream (s1) and the product stream (s2) and recovers the per-sample increment and the unknown multiplicand.
- The increment comes from a first difference of the running sum. The multiplicand comes from a sequential restoring divide of the product by the known multiplier operand.
- Sits on the output side of the accumulate/multiply datapath, feeding the self-check/scoreboard logic.

Parameters:
- DW, 8, data width of sum, divisor, difference and remainder. Product/quotient width is 2*DW.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  input sample present
- in_ready  output  1  block can accept a sample (high only in IDLE)
- s_in  input  DW  running-sum sample
- p_in  input  2*DW  product sample
- b_in  input  DW  divisor (multiplier operand)
- out_valid  output  1  result present (high only in DONE)
- out_ready  input  1  consumer accepts result
- d_out  output  DW  s_in minus previous accepted s_in, mod 2^DW
- q_out  output  2*DW  quotient p_in / b_in
- r_out  output  DW  remainder p_in mod b_in
- div_by_zero  output  1  result came from b_in == 0

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; in_ready=1; out_valid=0.
  - d_out, q_out, r_out, div_by_zero go to 0; previous-sum register goes to 0.
  - Reset has priority over every other event and aborts any division in progress. No result is produced for an aborted sample.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - Accept when in_valid && in_ready at an edge.
  - On accept: latch p_in as dividend and b_in as divisor. Set d_out = s_in - prev_sum (DW-bit wrap). Set prev_sum = s_in.
  - If b_in != 0: go to DIV with iteration count 0, partial remainder 0.
  - If b_in == 0: go to DONE with q_out = all ones, r_out = all ones, div_by_zero = 1.
- DIV:
  - One restoring iteration per edge, MSB first.
  - Each iteration: rem = {rem, next dividend bit}; if rem >= divisor, then rem -= divisor and the quotient bit is 1, else the quotient bit is 0.
  - Partial remainder is held in DW+1 bits.
  - After the 2*DW-th iteration (16 edges for DW=8): go to DONE, load q_out/r_out, div_by_zero = 0.
  - in_valid is ignored during DIV; in_ready = 0.
- DONE:
  - out_valid = 1; outputs held stable while out_ready = 0.
  - On out_valid && out_ready at an edge: go to IDLE. out_valid drops next cycle.
  - No same-edge re-accept: a new sample can be taken at the earliest one edge later, in IDLE.
- Latency, nonzero divisor: accept at edge N; out_valid high after edge N+2*DW (N+16).
- Latency, zero divisor: out_valid high after edge N+1.
- Max throughput: one sample per 2*DW+2 cycles.
- Output hold: d_out, q_out, r_out, div_by_zero keep their last values outside DONE; only out_valid qualifies them.
- The first sample after reset differences against 0, so d_out = s_in.
- Unsigned arithmetic throughout. Invariant: q_out*b_in + r_out == p_in and r_out < b_in whenever div_by_zero = 0.

Test Plan:
- Basic divide: reset, then accept s_in=5, p_in=35, b_in=7 -> out_valid 16 cycles after accept; q_out=5, r_out=0, d_out=5, div_by_zero=0.
- Remainder and difference: next sample s_in=12, p_in=1000, b_in=7 -> q_out=142, r_out=6, d_out=7. Then p_in=65535, b_in=255 -> q_out=257, r_out=0.
- Wrap and zero divisor: prev_sum=250, then s_in=4, p_in=100, b_in=0 -> d_out=10, q_out=16'hFFFF, r_out=8'hFF, div_by_zero=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and all outputs stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: drop rst at iteration 8 of a divide -> next cycle IDLE, out_valid=0, all outputs 0. The following sample s_in=9 gives d_out=9.
- Random check: 200 random (p_in, b_in != 0) pairs -> every result satisfies q_out*b_in + r_out == p_in and r_out < b_in, with d_out matching the scoreboard difference.
